// File: rtl/button_debouncer.sv
// Debounces a raw switch level: synchroniser chain, stability-checking FSM,
// and a registered output stage that produces Q/notQ plus one-cycle Rise/Fall strobes.
module button_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic D_raw,
    output logic Q,
    output logic notQ,
    output logic Rise,
    output logic Fall
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW    = 2'b00,
        CHK_HI = 2'b01,
        HIGH   = 2'b10,
        CHK_LO = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_s;
    logic                   w_level;

    assign w_s = r_sync[SYNC_STAGES-1];

    // The accepted level is "high" in HIGH and while still checking a drop in CHK_LO.
    assign w_level = (r_state == HIGH) || (r_state == CHK_LO);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], D_raw};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= LOW;
            r_cnt   <= '0;
            Q       <= 1'b0;
            notQ    <= 1'b1;
            Rise    <= 1'b0;
            Fall    <= 1'b0;
        end else begin
            // Outputs follow the FSM level one edge later, so strobes mark the edge Q itself changes.
            Q    <= w_level;
            notQ <= ~w_level;
            Rise <= w_level & ~Q;
            Fall <= ~w_level & Q;

            case (r_state)
                LOW: begin
                    if (w_s) begin
                        r_state <= CHK_HI;
                        r_cnt   <= '0;
                    end
                end
                CHK_HI: begin
                    if (!w_s) begin
                        r_state <= LOW;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!w_s) begin
                        r_state <= CHK_LO;
                        r_cnt   <= '0;
                    end
                end
                CHK_LO: begin
                    if (w_s) begin
                        r_state <= HIGH;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= LOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= LOW;
                end
            endcase
        end
    end

endmodule
